seg_scan_decoder: RTL and testbench

Receive-side counterpart to the team's 6-digit multiplexed 7-segment driver. Samples the scanned sel/seg lines, decodes each digit glyph, and assembles a full frame. Converts the frame back to a 20-bit binary value with 6-bit point mask and sign. Used as an on-chip loop-back checker and as a capture block for externally driven display buses.

---
 rtl/seg_scan_decoder_pkg.sv | 33 +++
 rtl/seg_glyph_dec.sv | 28 ++
 rtl/seg_scan_decoder.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared glyph patterns, digit codes and FSM encoding for the 7-segment scan decoder.
// The glyph decoder and the loop-back bench both import these definitions.
package seg_scan_decoder_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_MINUS = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd11;
  localparam logic [3:0] DIG_BAD   = 4'd15;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONV    = 2'd1,
    OUT     = 2'd2
  } state_t;

  // Minus, blank and illegal codes add nothing to the magnitude.
  function automatic logic [3:0] digit_value(input logic [3:0] code);
    return (code <= 4'd9) ? code : 4'd0;
  endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational lookup from an active-low 7-segment pattern (g..a) to a 4-bit digit code.
module seg_glyph_dec
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code
);

  always_comb begin
    code = DIG_BAD;
    case (pattern)
      GLYPH_0:     code = 4'd0;
      GLYPH_1:     code = 4'd1;
      GLYPH_2:     code = 4'd2;
      GLYPH_3:     code = 4'd3;
      GLYPH_4:     code = 4'd4;
      GLYPH_5:     code = 4'd5;
      GLYPH_6:     code = 4'd6;
      GLYPH_7:     code = 4'd7;
      GLYPH_8:     code = 4'd8;
      GLYPH_9:     code = 4'd9;
      GLYPH_MINUS: code = DIG_MINUS;
      GLYPH_BLANK: code = DIG_BLANK;
      default:     code = DIG_BAD;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Captures a scanned 6-digit 7-segment bus once each dwell has settled, assembles frames,
// and converts each completed frame to a 20-bit magnitude with point mask and sign.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYC = 16'd100
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [5:0]  sel_in,
  input  logic [7:0]  seg_in,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        data_valid,
  output logic        glyph_err
);

  logic [5:0]       sel_reg;
  logic [7:0]       seg_reg;
  logic [15:0]      cnt_reg;
  logic             done_reg;
  logic             sel_onehot;
  logic             in_changed;
  logic             capture;
  logic [3:0]       cap_code;

  logic [5:0][3:0]  slot_reg;
  logic [5:0]       pt_reg;
  logic [5:0]       mask_reg;
  logic             err_reg;
  logic [5:0]       slot_hit;
  logic             snap_go;

  logic [5:0][3:0]  snap_slot_reg;
  logic [5:0]       snap_pt_reg;
  logic             snap_err_reg;
  logic [5:0]       snap_minus;
  logic [19:0]      acc_reg;
  logic [2:0]       idx_reg;

  state_t           state_reg;
  state_t           state_next;
  logic             out_load;
  logic             out_err;

  logic [19:0]      data_reg;
  logic [5:0]       point_reg;
  logic             sign_reg;
  logic             data_valid_reg;
  logic             glyph_err_reg;

  assign sel_onehot = (sel_in != 6'd0) && ((sel_in & (sel_in - 6'd1)) == 6'd0);
  assign in_changed = (sel_in != sel_reg) || (seg_in != seg_reg);
  assign capture    = !in_changed && sel_onehot && !done_reg && (cnt_reg == SETTLE_CYC - 16'd1);
  assign snap_go    = (state_reg == COLLECT) && (mask_reg == 6'h3F);

  seg_glyph_dec u_glyph_dec (
    .pattern (seg_in[6:0]),
    .code    (cap_code)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_slot
      assign slot_hit[gi]   = capture && sel_in[gi];
      assign snap_minus[gi] = (snap_slot_reg[gi] == DIG_MINUS);
    end
  endgenerate

  // The done flag limits each stable dwell to a single capture.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_reg  <= '0;
      seg_reg  <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      sel_reg <= sel_in;
      seg_reg <= seg_in;
      if (in_changed || !sel_onehot) begin
        cnt_reg  <= '0;
        done_reg <= 1'b0;
      end else if (capture) begin
        done_reg <= 1'b1;
      end else if (!done_reg) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  // Collection keeps running during conversion; a full mask simply waits for COLLECT.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_reg <= '0;
      pt_reg   <= '0;
      mask_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      for (int n = 0; n < 6; n++) begin
        if (slot_hit[n]) begin
          slot_reg[n] <= cap_code;
          pt_reg[n]   <= ~seg_in[7];
        end
      end
      mask_reg <= (snap_go ? 6'd0 : mask_reg) | slot_hit;
      err_reg  <= (snap_go ? 1'b0 : err_reg) | (capture && (cap_code == DIG_BAD));
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      snap_slot_reg <= '0;
      snap_pt_reg   <= '0;
      snap_err_reg  <= 1'b0;
      acc_reg       <= '0;
      idx_reg       <= '0;
    end else if (snap_go) begin
      snap_slot_reg <= slot_reg;
      snap_pt_reg   <= pt_reg;
      snap_err_reg  <= err_reg;
      acc_reg       <= '0;
      idx_reg       <= 3'd5;
    end else if (state_reg == CONV) begin
      acc_reg <= (acc_reg << 3) + (acc_reg << 1) + {16'd0, digit_value(snap_slot_reg[idx_reg])};
      idx_reg <= idx_reg - 3'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_reg <= COLLECT;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (snap_go) state_next = CONV;
      CONV:    if (idx_reg == 3'd0) state_next = OUT;
      OUT:     state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    out_load = (state_reg == OUT) && !snap_err_reg;
    out_err  = (state_reg == OUT) && snap_err_reg;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_reg       <= '0;
      point_reg      <= '0;
      sign_reg       <= 1'b0;
      data_valid_reg <= 1'b0;
      glyph_err_reg  <= 1'b0;
    end else begin
      if (out_load) begin
        data_reg  <= acc_reg;
        point_reg <= snap_pt_reg;
        sign_reg  <= |snap_minus;
      end
      data_valid_reg <= out_load;
      glyph_err_reg  <= out_err;
    end
  end

  assign data       = data_reg;
  assign point      = point_reg;
  assign sign       = sign_reg;
  assign data_valid = data_valid_reg;
  assign glyph_err  = glyph_err_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans whole frames onto sel/seg and checks the
// decoded value, point mask, sign and result pulses against hand-computed expectations.
module tb_seg_scan_decoder;

  localparam logic [15:0] SETTLE = 16'd8;
  localparam int DWELL = 2 * int'(SETTLE);

  localparam logic [7:0] G0 = 8'hC0, G1 = 8'hF9, G2 = 8'hA4, G3 = 8'hB0, G4 = 8'h99;
  localparam logic [7:0] G5 = 8'h92, G6 = 8'h82, G7 = 8'hF8, G8 = 8'h80, G9 = 8'h90;
  localparam logic [7:0] GMIN = 8'hBF, GBL = 8'hFF, G4DOT = 8'h19, GBAD = 8'hAA;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [5:0]  sel_in = 6'd0;
  logic [7:0]  seg_in = 8'hFF;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        data_valid;
  logic        glyph_err;

  int vectors = 0;
  int miscompares = 0;
  int dv_cnt = 0;
  int err_cnt = 0;

  seg_scan_decoder #(.SETTLE_CYC(SETTLE)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sel_in     (sel_in),
    .seg_in     (seg_in),
    .data       (data),
    .point      (point),
    .sign       (sign),
    .data_valid (data_valid),
    .glyph_err  (glyph_err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (data_valid === 1'b1) dv_cnt++;
    if (glyph_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_digit(input logic [5:0] s, input logic [7:0] g, input int dwell);
    @(negedge sys_clk);
    sel_in = s;
    seg_in = g;
    repeat (dwell - 1) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [5:0][7:0] segs, input int dwell);
    for (int n = 5; n >= 0; n--) drive_digit(6'd1 << n, segs[n], dwell);
  endtask

  task automatic run_frame(input string tag, input logic [5:0][7:0] segs, input bit exp_ok,
                           input logic [19:0] exp_data, input logic [5:0] exp_point,
                           input logic exp_sign);
    int  dv0;
    int  er0;
    bit  seen;
    dv0  = dv_cnt;
    er0  = err_cnt;
    seen = 1'b0;
    send_frame(segs, DWELL);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (dv_cnt != dv0 || err_cnt != er0) seen = 1'b1;
      else @(negedge sys_clk);
    end
    check({tag, " result"}, 32'(seen), 32'd1);
    repeat (3) @(negedge sys_clk);
    check({tag, " valid pulses"}, 32'(dv_cnt - dv0), exp_ok ? 32'd1 : 32'd0);
    check({tag, " error pulses"}, 32'(err_cnt - er0), exp_ok ? 32'd0 : 32'd1);
    check({tag, " data"}, 32'(data), 32'(exp_data));
    check({tag, " point"}, 32'(point), 32'(exp_point));
    check({tag, " sign"}, 32'(sign), 32'(exp_sign));
    $display("frame %s: data=%0d point=%b sign=%b valid=%0d err=%0d",
             tag, data, point, sign, dv_cnt - dv0, err_cnt - er0);
  endtask

  initial begin
    int dv0;
    int er0;

    #2 sys_rst_n = 1'b0;
    #1;
    check("reset data", 32'(data), 32'd0);
    check("reset point", 32'(point), 32'd0);
    check("reset sign", 32'(sign), 32'd0);
    check("reset valid", 32'(data_valid), 32'd0);
    check("reset err", 32'(glyph_err), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    run_frame("123456", {G1, G2, G3, G4, G5, G6}, 1'b1, 20'd123456, 6'b000000, 1'b0);
    run_frame("minus42", {GBL, GBL, GBL, GMIN, G4DOT, G2}, 1'b1, 20'd42, 6'b000010, 1'b1);

    // Dwells one cycle short of settling, then a two-hot select held: nothing captured.
    dv0 = dv_cnt;
    er0 = err_cnt;
    send_frame({6{G1}}, int'(SETTLE) - 1);
    drive_digit(6'b000011, G5, 60);
    drive_digit(6'b000000, GBL, 20);
    check("short dwell valid", 32'(dv_cnt - dv0), 32'd0);
    check("short dwell err", 32'(err_cnt - er0), 32'd0);
    check("short dwell data", 32'(data), 32'd42);
    $display("frame short-dwell: data=%0d valid=%0d err=%0d", data, dv_cnt - dv0, err_cnt - er0);

    run_frame("999999", {6{G9}}, 1'b1, 20'hF423F, 6'b000000, 1'b0);
    run_frame("bad slot3", {G1, G1, GBAD, G1, G1, G1}, 1'b0, 20'hF423F, 6'b000000, 1'b0);
    run_frame("000000", {6{G0}}, 1'b1, 20'd0, 6'b000000, 1'b0);
    run_frame("333333", {6{G3}}, 1'b1, 20'd333333, 6'b000000, 1'b0);

    // Reset lands a few cycles after the final capture, while the conversion is running.
    dv0 = dv_cnt;
    er0 = err_cnt;
    for (int n = 5; n >= 1; n--) drive_digit(6'd1 << n, G8, DWELL);
    drive_digit(6'b000001, G8, int'(SETTLE) + 4);
    sys_rst_n = 1'b0;
    sel_in = 6'd0;
    seg_in = GBL;
    #1;
    check("mid-conv reset data", 32'(data), 32'd0);
    check("mid-conv reset point", 32'(point), 32'd0);
    check("mid-conv reset sign", 32'(sign), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("mid-conv reset valid", 32'(dv_cnt - dv0), 32'd0);
    check("mid-conv reset err", 32'(err_cnt - er0), 32'd0);
    check("mid-conv reset data held", 32'(data), 32'd0);
    $display("frame reset-in-conv: data=%0d valid=%0d err=%0d", data, dv_cnt - dv0, err_cnt - er0);

    run_frame("777777", {6{G7}}, 1'b1, 20'd777777, 6'b000000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
